// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - framed UART image loader into instruction memory
// Parses SYNC/LEN/data/CSUM frames, writes little-endian words from address 0, gates CPU reset.
module uart_program_loader #(
  parameter int         WORD_WIDTH    = 32,
  parameter int         ADDR_WIDTH    = 8,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         TIMEOUT_TICKS = 1600
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  tick,
  input  logic                  rx_done,
  input  logic [7:0]            rx_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic                  cpu_hold
);

  localparam int BPW = WORD_WIDTH / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [BIW-1:0] LAST_IDX = BIW'(BPW - 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

  state_t                state_q, state_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            word_cnt_q, word_cnt_d;
  logic [BIW-1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]            sum_q, sum_d;
  logic [WORD_WIDTH-1:0] wbuf_q, wbuf_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  load_done_q, load_done_d;
  logic                  load_err_q, load_err_d;
  logic                  cpu_hold_q, cpu_hold_d;

  logic                  in_frame, timeout, word_end, last_word;
  logic [WORD_WIDTH-1:0] assembled;

  // A byte arriving on the terminal tick wins over the timeout.
  assign in_frame  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign timeout   = in_frame && !rx_done && tick && (to_cnt_q == TO_LAST);
  assign word_end  = rx_done && (byte_idx_q == LAST_IDX);
  assign last_word = (word_cnt_q == len_q - 8'd1);

  always_comb begin
    assembled = wbuf_q;
    assembled[{byte_idx_q, 3'b000} +: 8] = rx_data;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (rx_done && rx_data == SYNC_BYTE) state_d = S_LEN;
      S_LEN: begin
        if (rx_done)      state_d = (rx_data == 8'd0) ? S_CSUM : S_DATA;
        else if (timeout) state_d = S_ERR;
      end
      S_DATA: begin
        if (rx_done) begin
          if (word_end && last_word) state_d = S_CSUM;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_CSUM: begin
        if (rx_done)      state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
        else if (timeout) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_idx_d  = byte_idx_q;
    sum_d       = sum_q;
    wbuf_d      = wbuf_q;
    to_cnt_d    = to_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_we_q ? mem_addr_q + 1'b1 : mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
    cpu_hold_d  = cpu_hold_q;
    busy_d      = (state_d != S_IDLE);

    if (in_frame) begin
      if (rx_done)   to_cnt_d = '0;
      else if (tick) to_cnt_d = to_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_done && rx_data == SYNC_BYTE) begin
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
          cpu_hold_d  = 1'b1;
          sum_d       = 8'd0;
          mem_addr_d  = '0;
          byte_idx_d  = '0;
          word_cnt_d  = 8'd0;
          to_cnt_d    = '0;
        end
      end
      S_LEN: begin
        if (rx_done) begin
          len_d = rx_data;
          sum_d = rx_data;
        end
      end
      S_DATA: begin
        if (rx_done) begin
          wbuf_d = assembled;
          sum_d  = sum_q + rx_data;
          if (word_end) begin
            byte_idx_d  = '0;
            word_cnt_d  = word_cnt_q + 8'd1;
            mem_wdata_d = assembled;
            mem_we_d    = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        load_done_d = 1'b1;
        cpu_hold_d  = 1'b0;
      end
      S_ERR: begin
        load_err_d = 1'b1;
        cpu_hold_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      len_q       <= 8'd0;
      word_cnt_q  <= 8'd0;
      byte_idx_q  <= '0;
      sum_q       <= 8'd0;
      wbuf_q      <= '0;
      to_cnt_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      cpu_hold_q  <= 1'b1;
    end else begin
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_idx_q  <= byte_idx_d;
      sum_q       <= sum_d;
      wbuf_q      <= wbuf_d;
      to_cnt_q    <= to_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      cpu_hold_q  <= cpu_hold_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign cpu_hold  = cpu_hold_q;

endmodule
